// File: rtl/shift_add_pkg.sv
// Shared types and defaults for the shift-add multiplier control FSM.
package shift_add_pkg;

  localparam int unsigned ITERATIONS_DEFAULT = 8;
  localparam int unsigned MAX_RUN_DEFAULT    = 9;

  // The watchdog counter must be able to hold MAX_RUN itself.
  function automatic int unsigned wdog_width(input int unsigned max_run);
    return $clog2(max_run + 1);
  endfunction

  localparam int unsigned WDOG_W_DEFAULT = $clog2(MAX_RUN_DEFAULT + 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_RUN  = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

endpackage

// File: rtl/shift_add_control_if.sv
// Host/datapath/counter signal bundle for the shift-add control FSM.
interface shift_add_control_if;
  logic Start;
  logic M0;
  logic K;
  logic Load;
  logic Ad;
  logic Sh;
  logic Busy;
  logic Done;
  logic Err;

  modport master (
    output Start, M0, K,
    input  Load, Ad, Sh, Busy, Done, Err
  );

  modport slave (
    input  Start, M0, K,
    output Load, Ad, Sh, Busy, Done, Err
  );
endinterface

// File: rtl/shift_add_watchdog.sv
// Saturating RUN-cycle counter; flags the RUN cycle in which MAX_RUN is reached.
module shift_add_watchdog
  import shift_add_pkg::*;
#(
  parameter int unsigned MAX_RUN = MAX_RUN_DEFAULT
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clear,
  input  logic run,
  output logic expire_c
);

  localparam int unsigned CW = wdog_width(MAX_RUN);

  logic [CW-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (Rst || clear) begin
      cnt <= '0;
    end else if (run && (cnt != CW'(MAX_RUN))) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Expires during the MAX_RUN-th RUN cycle, so the count lands on MAX_RUN as ERR is entered.
  assign expire_c = run && (cnt >= CW'(MAX_RUN - 1));

endmodule

// File: rtl/shift_add_control.sv
// Control FSM for the 8-bit shift-add multiplier.
// Optional watchdog/ERR state enabled by defining SHIFT_ADD_TIMEOUT_EN.
module shift_add_control
  import shift_add_pkg::*;
#(
  parameter int unsigned ITERATIONS = ITERATIONS_DEFAULT,
  parameter int unsigned MAX_RUN    = MAX_RUN_DEFAULT
) (
  input logic          Clk,
  input logic          Rst,
  shift_add_control_if.slave bus
);

  if (ITERATIONS == 0 || MAX_RUN < ITERATIONS) begin : g_bad_cfg
    $error("shift_add_control: require 0 < ITERATIONS <= MAX_RUN");
  end

  state_e state_q;
  state_e state_d;
  logic   load_q;
  logic   sh_q;
  logic   busy_q;
  logic   done_q;
  logic   wdog_expire_c;

`ifdef SHIFT_ADD_TIMEOUT_EN
  logic err_q;

  shift_add_watchdog #(
    .MAX_RUN (MAX_RUN)
  ) u_watchdog (
    .Clk      (Clk),
    .Rst      (Rst),
    .clear    (state_q == ST_INIT),
    .run      (state_q == ST_RUN),
    .expire_c (wdog_expire_c)
  );

  assign bus.Err = err_q;
`else
  assign wdog_expire_c = 1'b0;
  assign bus.Err       = 1'b0;
`endif

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.Start) state_d = ST_INIT;
      ST_INIT: state_d = ST_RUN;
      ST_RUN: begin
        if (bus.K)              state_d = ST_DONE;
        else if (wdog_expire_c) state_d = ST_ERR;
      end
      ST_DONE: if (!bus.Start) state_d = ST_IDLE;
`ifdef SHIFT_ADD_TIMEOUT_EN
      ST_ERR:  state_d = ST_ERR;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; Load is held high through reset to keep the counter cleared.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      load_q  <= 1'b1;
      sh_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SHIFT_ADD_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      load_q  <= (state_d == ST_INIT);
      sh_q    <= (state_d == ST_RUN);
      busy_q  <= (state_d == ST_INIT) || (state_d == ST_RUN);
      done_q  <= (state_d == ST_DONE);
`ifdef SHIFT_ADD_TIMEOUT_EN
      err_q   <= (state_d == ST_ERR);
`endif
    end
  end

  assign bus.Load = load_q;
  assign bus.Sh   = sh_q;
  assign bus.Busy = busy_q;
  assign bus.Done = done_q;
  assign bus.Ad   = sh_q & bus.M0;

endmodule
